// File: rtl/opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
//  Module   : opb_register_bank_ppc2simulink
//  Purpose  : Bank of C_NUM_REGS PPC-writable 32-bit software registers on a
//             single OPB slave window. Byte-lane writes, read-back,
//             error acknowledge for in-window addresses past the last
//             register, a one-cycle write strobe per register and optional
//             per-register auto-clear. The user side runs on OPB_Clk.
//  Ports    : OPB_Clk, OPB_Rst_n (async, active low)
//             OPB_ABus/BE/DBus/RNW/select/seqAddr  - OPB master request
//             Sl_DBus/errAck/retry/toutSup/xferAck - OPB slave response
//             user_data_out - register i on bits [32i+31:32i]
//             user_wr_stb   - one-cycle pulse when register i is written
//  Revision : 1.0  initial release
// ============================================================================
module opb_register_bank_ppc2simulink #(
   parameter logic [31:0] C_BASEADDR     = 32'h0100_0100,
   parameter logic [31:0] C_HIGHADDR     = 32'h0100_01FF,
   parameter int          C_OPB_AWIDTH   = 32,
   parameter int          C_OPB_DWIDTH   = 32,
   parameter int          C_NUM_REGS     = 8,
   parameter logic [31:0] C_RESET_VAL    = 32'h0,
   parameter logic [63:0] C_AUTOCLR_MASK = 64'h0,
   parameter              C_FAMILY       = "virtex5"
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   output logic                      Sl_xferAck,
   output logic [32*C_NUM_REGS-1:0]  user_data_out,
   output logic [C_NUM_REGS-1:0]     user_wr_stb
);

   localparam int IDXW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

   // Elaboration-time guard against parameter sets the datapath cannot honour.
   if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 || C_NUM_REGS < 1 || C_NUM_REGS > 64 ||
       (64'(4 * C_NUM_REGS) > ({32'd0, C_HIGHADDR} - {32'd0, C_BASEADDR} + 64'd1)) ||
       C_FAMILY == "") begin : g_param_error
      $error("opb_register_bank_ppc2simulink: unsupported parameter set");
   end

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } state_t;

   state_t            state, next_state;
   logic [31:0]       offset;
   logic [29:0]       word;
   logic              hit, in_range, do_write;
   logic [IDXW-1:0]   addr_idx;

   logic [IDXW-1:0]   idx_q;
   logic              valid_q, rnw_q;
   logic [0:3]        be_q;
   logic [31:0]       wdata_q, rdata_q;

   logic [31:0]       regs [C_NUM_REGS];
   logic [C_NUM_REGS-1:0] wr_stb;

   // Burst hint is treated as a plain transfer; the two low address bits
   // carry no information for word registers.
   logic unused_inputs;
   assign unused_inputs = ^{OPB_seqAddr, offset[1:0]};

   // ---------------------------------------------------------------- decode
   assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign offset   = OPB_ABus - C_BASEADDR;
   assign word     = offset[31:2];
   assign in_range = (word < 30'(C_NUM_REGS));
   assign addr_idx = word[IDXW-1:0];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) state <= S_IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (hit) next_state = S_ACK;
         S_ACK:   next_state = S_IDLE;   // one-cycle ack; a hit seen here is dropped
         default: next_state = S_IDLE;
      endcase
   end

   // Acks are decoded from the state register so an async reset drops them at once.
   always_comb begin
      Sl_xferAck = (state == S_ACK) &&  valid_q;
      Sl_errAck  = (state == S_ACK) && !valid_q;
      do_write   = (state == S_ACK) &&  valid_q && !rnw_q;
      Sl_DBus    = ((state == S_ACK) && valid_q && rnw_q) ? rdata_q : '0;
   end

   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   // ---------------------------------------------------------------- request capture
   // The read mux is registered at the accepting edge, so the ack cycle
   // drives a flop straight onto the bus.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         idx_q   <= '0;
         valid_q <= 1'b0;
         rnw_q   <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else if (state == S_IDLE && hit) begin
         idx_q   <= addr_idx;
         valid_q <= in_range;
         rnw_q   <= OPB_RNW;
         be_q    <= OPB_BE;
         wdata_q <= OPB_DBus;
         rdata_q <= in_range ? regs[addr_idx] : '0;
      end
   end

   // ---------------------------------------------------------------- register bank
   // Auto-clear fires the cycle after the strobe; a write to the same register
   // cannot land in that cycle, but the write is placed last so it would win.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= C_RESET_VAL;
         wr_stb <= '0;
      end else begin
         wr_stb <= '0;
         for (int i = 0; i < C_NUM_REGS; i++) begin
            if (C_AUTOCLR_MASK[i] && wr_stb[i]) regs[i] <= '0;
            if (do_write && (int'(idx_q) == i)) begin
               // BE[0] is the OPB MSB lane, i.e. user bits [31:24].
               for (int b = 0; b < 4; b++) begin
                  if (be_q[b]) regs[i][31-8*b -: 8] <= wdata_q[31-8*b -: 8];
               end
               wr_stb[i] <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_user_out
      assign user_data_out[32*g +: 32] = regs[g];
   end

   assign user_wr_stb = wr_stb;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_opb_register_bank_ppc2simulink
//  Purpose  : Self-checking bench for opb_register_bank_ppc2simulink.
//             Directed scenarios followed by randomized transfers checked
//             against a word-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_opb_register_bank_ppc2simulink;

   localparam logic [31:0] BASE    = 32'h0100_0100;
   localparam logic [31:0] HIGH    = 32'h0100_01FF;
   localparam int          NREGS   = 8;
   localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;
   localparam logic [63:0] ACLR    = 64'h1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [0:31]           abus = '0;
   logic [0:3]            be = '0;
   logic [0:31]           dbus = '0;
   logic                  rnw = 1'b0, sel = 1'b0, seq = 1'b0;
   logic [0:31]           sl_dbus;
   logic                  err_ack, retry, tout_sup, xfer_ack;
   logic [32*NREGS-1:0]   user_data;
   logic [NREGS-1:0]      wr_stb;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [NREGS];

   opb_register_bank_ppc2simulink #(
      .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
      .C_NUM_REGS(NREGS), .C_RESET_VAL(RST_VAL), .C_AUTOCLR_MASK(ACLR), .C_FAMILY("virtex5")
   ) dut (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
      .Sl_DBus(sl_dbus), .Sl_errAck(err_ack), .Sl_retry(retry), .Sl_toutSup(tout_sup),
      .Sl_xferAck(xfer_ack), .user_data_out(user_data), .user_wr_stb(wr_stb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model_bus();
      logic [255:0] v = '0;
      for (int i = 0; i < NREGS; i++) v[32*i +: 32] = model[i];
      return v;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [0:3] b);
      logic [31:0] m = '0;
      for (int k = 0; k < 4; k++) if (b[k]) m |= 32'hFF << (24 - 8*k);
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) model[i] = RST_VAL;
   endtask

   // One complete transfer starting at a negedge; ends at a negedge two idle
   // cycles after the ack, so any auto-clear has already taken effect.
   task automatic xfer(input logic [31:0] addr, input logic r, input logic [0:3] b,
                       input logic [31:0] d);
      logic           in_win, valid;
      int             idx;
      logic [31:0]    exp_rd, m;
      logic [NREGS-1:0] exp_stb;
      in_win = (addr >= BASE) && (addr <= HIGH);
      idx    = int'((addr - BASE) >> 2);
      valid  = in_win && (idx < NREGS);
      exp_rd = '0;
      if (valid) exp_rd = model[idx];
      abus = addr; rnw = r; be = b; dbus = d; sel = 1'b1;
      @(negedge clk);
      sel = 1'b0; abus = $urandom; dbus = $urandom; be = 4'($urandom);
      chk("xfer_ack", 256'(xfer_ack), 256'(valid));
      chk("err_ack", 256'(err_ack), 256'(in_win && !valid));
      chk("rd_data", 256'(sl_dbus), 256'((valid && r) ? exp_rd : 32'h0));
      exp_stb = '0;
      if (valid && !r) begin
         m = lane_mask(b);
         model[idx] = (model[idx] & ~m) | (d & m);
         exp_stb[idx] = 1'b1;
      end
      @(negedge clk);
      chk("ack_single", 256'({xfer_ack, err_ack}), 256'(0));
      chk("dbus_idle", 256'(sl_dbus), 256'(0));
      chk("wr_stb", 256'(wr_stb), 256'(exp_stb));
      chk("user_data", user_data, model_bus());
      if (valid && !r && ACLR[idx]) model[idx] = '0;
      @(negedge clk);
      chk("wr_stb_off", 256'(wr_stb), 256'(0));
      chk("user_data_after", user_data, model_bus());
   endtask

   initial begin
      logic [31:0] a, d1, d2;
      int          kind;
      model_reset();
      // ---------------- reset
      repeat (2) @(negedge clk);
      chk("rst_user_data", user_data, model_bus());
      chk("rst_acks", 256'({xfer_ack, err_ack, retry, tout_sup}), 256'(0));
      chk("rst_dbus", 256'(sl_dbus), 256'(0));
      chk("rst_stb", 256'(wr_stb), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // ---------------- full write then read-back of reg 3
      xfer(BASE + 32'hC, 1'b0, 4'b1111, 32'hDEAD_BEEF);
      chk("reg3_full", 256'(user_data[127:96]), 256'(32'hDEAD_BEEF));
      xfer(BASE + 32'hC, 1'b1, 4'b0000, 32'h0);
      // ---------------- byte-lane write
      xfer(BASE + 32'hC, 1'b0, 4'b0101, 32'h1122_3344);
      chk("reg3_lanes", 256'(user_data[127:96]), 256'(32'hDE22_BE44));
      // ---------------- strobe with no lanes enabled
      xfer(BASE + 32'h8, 1'b0, 4'b0000, 32'hFFFF_FFFF);
      // ---------------- in-window, index out of range
      xfer(BASE + 4*NREGS, 1'b0, 4'b1111, 32'h1234_5678);
      xfer(BASE + 4*NREGS, 1'b1, 4'b1111, 32'h0);
      // ---------------- auto-clear register 0
      xfer(BASE, 1'b0, 4'b1111, 32'h5);
      chk("aclr_cleared", 256'(user_data[31:0]), 256'(0));
      xfer(BASE, 1'b1, 4'b1111, 32'h0);

      // ---------------- back-to-back with select held and seqAddr
      d1 = $urandom; d2 = $urandom;
      abus = BASE + 32'h4; rnw = 1'b0; be = 4'b1111; dbus = d1; sel = 1'b1; seq = 1'b1;
      @(negedge clk);
      chk("b2b_ack1", 256'(xfer_ack), 256'(1));
      model[1] = d1;
      abus = BASE + 32'h8; dbus = d2;
      @(negedge clk);
      chk("b2b_gap", 256'(xfer_ack), 256'(0));
      chk("b2b_stb1", 256'(wr_stb), 256'(8'h02));
      chk("b2b_data1", user_data, model_bus());
      @(negedge clk);
      chk("b2b_ack2", 256'(xfer_ack), 256'(1));
      model[2] = d2;
      sel = 1'b0; seq = 1'b0;
      @(negedge clk);
      chk("b2b_end", 256'(xfer_ack), 256'(0));
      chk("b2b_stb2", 256'(wr_stb), 256'(8'h04));
      chk("b2b_data2", user_data, model_bus());
      @(negedge clk);

      // ---------------- reset in the ack cycle
      abus = BASE + 32'h14; rnw = 1'b0; be = 4'b1111; dbus = 32'hCAFE_F00D; sel = 1'b1;
      @(negedge clk);
      chk("mid_ack", 256'(xfer_ack), 256'(1));
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_ack_drop", 256'({xfer_ack, err_ack}), 256'(0));
      chk("mid_dbus", 256'(sl_dbus), 256'(0));
      chk("mid_regs", user_data, model_bus());
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_no_commit", user_data, model_bus());
      chk("mid_no_stb", 256'(wr_stb), 256'(0));

      // ---------------- randomized transfers
      for (int n = 0; n < 80; n++) begin
         kind = int'($urandom_range(0, 9));
         case (kind)
            0:       a = BASE - 32'(4 * $urandom_range(1, 16));
            1:       a = HIGH + 32'd1 + 32'(4 * $urandom_range(0, 16));
            2:       a = BASE + 32'(4 * $urandom_range(NREGS, 63));
            default: a = BASE + 32'(4 * $urandom_range(0, NREGS - 1));
         endcase
         a = a | 32'($urandom_range(0, 3));
         xfer(a, 1'($urandom), 4'($urandom), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
